prog_truth_table: RTL and testbench
===================================

// Module: prog_truth_table
// PURPOSE
//  Registered, runtime-programmable N-input boolean function unit (truth-table LUT).
//  Replaces fixed-equation combinational function blocks. Its function is reloaded
//  serially at runtime without stopping evaluation.
//  Sits between input-capture logic and downstream control; one evaluation per valid input.
// PARAMETERS
//  N_IN     3       number of function inputs (1..6); table width TT_W = 2**N_IN
//  INIT_TT  8'h31   table loaded at reset; bit[i] = output for input vector value i
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      in_vec is valid this cycle
//  in_vec     in   N_IN   function inputs; in_vec[N_IN-1] is MSB of the table index
//  out_valid  out  1      y carries a new result this cycle
//  y          out  1      registered function result
//  cfg_start  in   1      pulse: begin loading a new table
//  cfg_valid  in   1      cfg_bit is valid this cycle
//  cfg_bit    in   1      serial table bit, MSB (index TT_W-1) first
//  cfg_busy   out  1      high while a load is in progress
//  cfg_done   out  1      one-cycle pulse: new table is committed
// BEHAVIOUR
//  Interface: one clock, clk; reset is synchronous and active-high, named reset.
//  Reset values: active table = INIT_TT, shadow = 0, y=0, out_valid=0, cfg_busy=0,
//   cfg_done=0, state=IDLE, bit counter=0.
//  Evaluation: latency 1. If in_valid at edge k: at k+1, y = active_tt[in_vec] and
//   out_valid=1. If in_valid=0: out_valid=0 and y holds its last value.
//  Evaluation never stalls. It runs in every state, including during a load.
//  Load FSM, 2 states:
//   IDLE: cfg_start -> LOAD, counter=0, cfg_busy=1. cfg_valid is ignored.
//   LOAD: each cfg_valid shifts cfg_bit into shadow (shadow = {shadow, cfg_bit}) and
//    increments the counter.
//    On the TT_W-th bit: active_tt <= the completed shadow, cfg_done=1 on the next
//    cycle, -> IDLE, cfg_busy=0.
//  The commit is atomic. An evaluation in the same cycle as the commit edge uses the
//   old table. Evaluations from the next edge onward use the new table.
//  Gaps: cfg_valid=0 cycles in LOAD are permitted. The load waits indefinitely.
//  Restart: cfg_start while in LOAD discards the partial shadow and resets the counter
//   to 0. The cfg_bit in that cycle is ignored. State stays LOAD.
//  cfg_start and cfg_valid in the same cycle (any state): start wins, the bit is dropped.
//  Reset mid-load: partial data is lost and the active table returns to INIT_TT.
//  Counter is N_IN+1 bits wide, so the final count TT_W does not wrap.
//  No combinational path from any input to any output.
// STRUCTURE
//  Shared package prog_tt_pkg holds:
//   - state encoding: IDLE=1'b0, LOAD=1'b1
//   - function tt_w(n) = 1<<n
//  Sub-module tt_shift_loader holds the FSM, counter and shadow register. Its outputs
//   are shadow, commit pulse and busy.
//  The top level holds the active table, the evaluation mux and the output registers.
// TESTING
//  1 Reset, INIT_TT=8'h31; drive in_vec 0..7 back-to-back with in_valid=1.
//    Expect y = 1,0,0,0,1,1,0,0, each one cycle later, with out_valid=1.
//  2 Load 8'hFE MSB-first with no gaps. Expect cfg_done 1 cycle after the 8th bit.
//    Then in_vec=0 -> y=0 and in_vec=5 -> y=1. cfg_busy=1 for exactly 8 cycles.
//  3 Drive in_vec=3 continuously while loading 8'h08 with random cfg_valid gaps.
//    Expect y=0 up to and including the commit edge, then y=1.
//  4 Send 5 bits of 8'hFF, pulse cfg_start (with cfg_valid=1), then load 8'h80.
//    Expect the final table 8'h80: in_vec=7 -> 1, in_vec=6 -> 0.
//  5 Assert reset after 4 bits of a load.
//    Expect cfg_busy=0, the table restored to 8'h31, and in_vec=4 -> y=1.
//  6 Hold in_valid=0 for 10 cycles after a y=1 result. Expect out_valid=0 and y held at 1.

Source files
------------

// File: rtl/prog_tt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_tt_pkg
// Purpose  : Shared definitions for the programmable truth-table unit:
//            load-FSM state encoding and the table-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package prog_tt_pkg;

  // Load sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

  // Number of table entries for an n-input function.
  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_shift_loader.sv
`default_nettype none
// ============================================================================
// Module   : tt_shift_loader
// Purpose  : Serial loader for a truth table. Collects TT_W bits MSB-first into
//            a shadow register and flags the cycle on which the table completes.
// Ports    : clk, reset  - clock, synchronous active-high reset
//            i_start     - begin (or restart) a load; wins over i_valid
//            i_valid     - i_bit carries a table bit this cycle
//            i_bit       - serial table bit, MSB first
//            o_shadow    - completed table (shadow with the current bit appended),
//                          meaningful when o_commit is high
//            o_commit    - high in the cycle whose edge accepts the last bit
//            o_busy      - a load is in progress
// Revision : 1.0 - initial release
// ============================================================================
module tt_shift_loader
  import prog_tt_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic                    i_valid,
  input  logic                    i_bit,
  output logic [tt_w(N_IN)-1:0]   o_shadow,
  output logic                    o_commit,
  output logic                    o_busy
);

  localparam int             c_tt_w      = tt_w(N_IN);
  // Counter is one bit wider than the index so the full count does not wrap.
  localparam logic [N_IN:0]  c_cnt_full  = (N_IN+1)'(c_tt_w);

  load_state_e          r_state;
  logic [N_IN:0]        r_cnt;
  logic [c_tt_w-1:0]    r_shadow;

  logic [c_tt_w-1:0]    w_shift;
  logic [N_IN:0]        w_cnt_inc;
  logic                 w_accept;
  logic                 w_commit;

  assign w_shift   = {r_shadow[c_tt_w-2:0], i_bit};
  assign w_cnt_inc = r_cnt + 1'b1;
  // A start in the same cycle drops the bit.
  assign w_accept  = (r_state == LOAD) && i_valid && !i_start;
  assign w_commit  = w_accept && (w_cnt_inc == c_cnt_full);

  // The completed table is handed over combinationally so the top can commit
  // it on the very edge that accepts the last bit.
  assign o_shadow  = w_shift;
  assign o_commit  = w_commit;
  assign o_busy    = (r_state == LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state  <= LOAD;
            r_cnt    <= '0;
            r_shadow <= '0;
          end
        end
        LOAD: begin
          if (i_start) begin
            // Restart: discard the partial table, stay in LOAD.
            r_cnt    <= '0;
            r_shadow <= '0;
          end else if (i_valid) begin
            r_shadow <= w_shift;
            r_cnt    <= w_cnt_inc;
            if (w_commit) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_truth_table.sv
`default_nettype none
// ============================================================================
// Module   : prog_truth_table
// Purpose  : Registered N-input boolean function unit backed by a truth table
//            that can be reloaded serially while evaluation keeps running.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            in_valid, in_vec      - evaluation request; in_vec is the table index
//            out_valid, y          - result, one cycle after in_valid
//            cfg_start             - begin/restart a table load
//            cfg_valid, cfg_bit    - serial table bits, MSB (index TT_W-1) first
//            cfg_busy              - load in progress
//            cfg_done              - one-cycle pulse after the new table commits
// Revision : 1.0 - initial release
// ============================================================================
module prog_truth_table
  import prog_tt_pkg::*;
#(
  parameter int                   N_IN    = 3,
  parameter logic [tt_w(N_IN)-1:0] INIT_TT = 8'h31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_vec,
  output logic              out_valid,
  output logic              y,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_busy,
  output logic              cfg_done
);

  localparam int c_tt_w = tt_w(N_IN);

  logic [c_tt_w-1:0] r_active_tt;
  logic              r_y;
  logic              r_out_valid;
  logic              r_cfg_done;

  logic [c_tt_w-1:0] w_shadow;
  logic              w_commit;
  logic              w_busy;

  tt_shift_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk      (clk),
    .reset    (reset),
    .i_start  (cfg_start),
    .i_valid  (cfg_valid),
    .i_bit    (cfg_bit),
    .o_shadow (w_shadow),
    .o_commit (w_commit),
    .o_busy   (w_busy)
  );

  // Evaluation reads r_active_tt before this edge's update, so a lookup on
  // the commit edge still sees the old table.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active_tt <= INIT_TT;
      r_y         <= 1'b0;
      r_out_valid <= 1'b0;
      r_cfg_done  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_y <= r_active_tt[in_vec];
      end
      if (w_commit) begin
        r_active_tt <= w_shadow;
      end
      r_cfg_done <= w_commit;
    end
  end

  assign y         = r_y;
  assign out_valid = r_out_valid;
  assign cfg_done  = r_cfg_done;
  assign cfg_busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_prog_truth_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_truth_table
// Purpose  : Self-checking bench for prog_truth_table (N_IN=3, INIT_TT=8'h31).
//            A behavioural model predicts every output each cycle; directed
//            scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_truth_table;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_vec;
  logic       out_valid;
  logic       y;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_busy;
  logic       cfg_done;

  int n_checks = 0;
  int n_errors = 0;

  prog_truth_table #(
    .N_IN    (3),
    .INIT_TT (8'h31)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .y         (y),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_tt;       // active table as an integer
  int   m_bits;     // bits gathered so far, as an integer
  int   m_nbits;    // number of bits gathered
  bit   m_loading;
  logic e_y, e_ov, e_done;

  always @(posedge clk) begin
    if (reset) begin
      m_tt      <= 'h31;
      m_bits    <= 0;
      m_nbits   <= 0;
      m_loading <= 1'b0;
      e_y       <= 1'b0;
      e_ov      <= 1'b0;
      e_done    <= 1'b0;
    end else begin
      e_ov <= in_valid;
      if (in_valid) e_y <= ((m_tt >> in_vec) & 1) != 0;
      e_done <= 1'b0;
      if (cfg_start) begin
        m_loading <= 1'b1;
        m_bits    <= 0;
        m_nbits   <= 0;
      end else if (m_loading && cfg_valid) begin
        if (m_nbits == 7) begin
          m_tt      <= m_bits * 2 + int'(cfg_bit);
          m_loading <= 1'b0;
          e_done    <= 1'b1;
        end else begin
          m_bits  <= m_bits * 2 + int'(cfg_bit);
          m_nbits <= m_nbits + 1;
        end
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_valid", out_valid, e_ov);
      check("model_y",         y,         e_y);
      check("model_cfg_busy",  cfg_busy,  m_loading);
      check("model_cfg_done",  cfg_done,  e_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic eval_lit(input int v, input bit exp);
    in_valid = 1'b1;
    in_vec   = 3'(v);
    @(negedge clk);
    in_valid = 1'b0;
    check("lit_out_valid", out_valid, 1'b1);
    check($sformatf("lit_y_vec%0d", v), y, exp);
  endtask

  task automatic start_pulse(input bit with_valid);
    cfg_start = 1'b1;
    cfg_valid = with_valid;
    cfg_bit   = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  // Send the top n bits of val MSB first; counts cycles with cfg_busy high.
  task automatic send_bits(input logic [7:0] val, input int n, input bit gaps,
                           output int busy_cyc);
    busy_cyc = 0;
    for (int i = 7; i > 7 - n; i--) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          if (cfg_busy) busy_cyc++;
        end
      end
      cfg_valid = 1'b1;
      cfg_bit   = val[i];
      @(negedge clk);
      cfg_valid = 1'b0;
      if (cfg_busy) busy_cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1;
    int bc;
    reset = 1'b1; in_valid = 1'b0; in_vec = '0;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    // reset state
    check("rst_y", y, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_cfg_busy", cfg_busy, 1'b0);
    check("rst_cfg_done", cfg_done, 1'b0);
    reset = 1'b0;

    // 1: reset table, all indices back-to-back
    t1 = 8'b0011_0001;
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1;
      in_vec   = 3'(v);
      @(negedge clk);
      check("t1_out_valid", out_valid, 1'b1);
      check($sformatf("t1_y_vec%0d", v), y, t1[v]);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // 2: load FE with no gaps
    start_pulse(1'b0);
    check("t2_busy_after_start", cfg_busy, 1'b1);
    send_bits(8'hFE, 8, 1'b0, bc);
    check("t2_done", cfg_done, 1'b1);
    check("t2_busy_cycles", bc + 1, 8);   // +1 for the cycle after start
    @(negedge clk);
    check("t2_done_single", cfg_done, 1'b0);
    eval_lit(0, 1'b0);
    eval_lit(5, 1'b1);

    // 3: continuous eval of index 3 while loading 08 with gaps (from table 31)
    do_reset();
    in_valid = 1'b1; in_vec = 3'd3;
    start_pulse(1'b0);
    send_bits(8'h08, 8, 1'b1, bc);
    check("t3_done", cfg_done, 1'b1);
    check("t3_y_at_commit_edge", y, 1'b0);
    @(negedge clk);
    check("t3_y_after_commit", y, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);

    // 4: restart mid-load
    start_pulse(1'b0);
    send_bits(8'hFF, 5, 1'b0, bc);
    start_pulse(1'b1);
    check("t4_busy_after_restart", cfg_busy, 1'b1);
    send_bits(8'h80, 8, 1'b0, bc);
    check("t4_done", cfg_done, 1'b1);
    eval_lit(7, 1'b1);
    eval_lit(6, 1'b0);
    eval_lit(0, 1'b0);

    // 5: reset mid-load restores INIT_TT
    start_pulse(1'b0);
    send_bits(8'h0F, 4, 1'b0, bc);
    do_reset();
    check("t5_busy", cfg_busy, 1'b0);
    check("t5_done", cfg_done, 1'b0);
    eval_lit(4, 1'b1);
    eval_lit(1, 1'b0);

    // 6: hold after y=1
    eval_lit(0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_out_valid", out_valid, 1'b0);
      check("t6_y_held", y, 1'b1);
    end

    // start and cfg_valid together in IDLE: bit dropped, 8 more bits needed
    start_pulse(1'b1);
    send_bits(8'h01, 7, 1'b0, bc);
    check("t7_not_done_after7", cfg_done, 1'b0);
    check("t7_busy_after7", cfg_busy, 1'b1);
    send_bits(8'h80, 1, 1'b0, bc);
    check("t7_done", cfg_done, 1'b1);
    eval_lit(0, 1'b1);
    eval_lit(4, 1'b0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
